layer_start_dispatch: RTL

LAYER_START_DISPATCH -- requirements
Module: layer_start_dispatch

---
 rtl/layer_start_dispatch.sv | 78 +++++++
 1 files changed

// File: rtl/layer_start_dispatch.sv
// layer_start_dispatch: runs NUM_LAYERS start/wait rounds over up to four units, with a per-round timeout
module layer_start_dispatch #(
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [3:0] port_mask,
    input  logic       port_done_1,
    input  logic       port_done_2,
    input  logic       port_done_3,
    input  logic       port_done_4,
    output logic       port_start_1,
    output logic       port_start_2,
    output logic       port_start_3,
    output logic       port_start_4,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [3:0] layer_idx
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_FIN, S_ERR} state_t;
    state_t     r_state, w_next;
    logic [3:0] r_mask, r_flags, r_layer, w_done_in, w_start;
    logic [7:0] r_timer;
    logic       w_accept, w_complete, w_last, w_expired;
    assign w_done_in  = {port_done_4, port_done_3, port_done_2, port_done_1};
    assign w_accept   = go && (r_state == S_IDLE || r_state == S_ERR);
    // a done arriving in the current WAIT cycle already counts toward completion
    assign w_complete = ((r_flags | w_done_in) & r_mask) == r_mask;
    assign w_last     = r_layer == 4'(NUM_LAYERS - 1);
    assign w_expired  = r_timer == 8'(TIMEOUT_CYCLES - 1);
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ERR: w_next = go ? S_START : r_state;
            S_START:       w_next = S_WAIT;
            S_WAIT:        w_next = w_complete ? S_NEXT : (w_expired ? S_ERR : S_WAIT);
            S_NEXT:        w_next = w_last ? S_FIN : S_START;
            S_FIN:         w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_flags <= '0;
            r_timer <= '0;
            r_layer <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mask  <= port_mask;
                r_layer <= '0;
            end
            if (r_state == S_START) begin
                r_flags <= '0;
                r_timer <= '0;
            end
            if (r_state == S_WAIT) begin
                r_flags <= r_flags | (w_done_in & r_mask);
                r_timer <= r_timer + 8'd1;
            end
            if (r_state == S_NEXT && !w_last) r_layer <= r_layer + 4'd1;
        end
    end
    assign w_start      = (r_state == S_START) ? r_mask : 4'b0;
    assign port_start_1 = w_start[0];
    assign port_start_2 = w_start[1];
    assign port_start_3 = w_start[2];
    assign port_start_4 = w_start[3];
    assign busy         = !(r_state == S_IDLE || r_state == S_ERR);
    assign done         = r_state == S_FIN;
    assign timeout      = r_state == S_ERR;
    assign layer_idx    = r_layer;
endmodule
